branch_predict_unit: RTL and testbench

Fetch-side branch predictor and decode-side branch resolver for the 5-stage MIPS pipeline. It drives `predictF` and the predicted target into fetch. One cycle later it compares the `predictD` value carried through the IF/ID register against the outcome resolved in decode. On a mismatch it drives `Flush` into IF/ID and supplies the corrected PC. Prediction state is a table of 2-bit saturating counters indexed by PC, plus two performance counters.

---
 rtl/mips_pkg.sv | 10 +
 rtl/sat_counter2.sv | 13 +
 rtl/branch_predict_unit.sv | 72 +++++++
 tb/tb_branch_predict_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes and 2-bit branch predictor counter encodings.
package mips_pkg;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;
  localparam logic [1:0] BP_RESET = BP_WNT;
endpackage

// File: rtl/sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating taken/not-taken counter.
module sat_counter2
  import mips_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);
  always_comb begin
    cnt_o = taken_i ? ((cnt_i == BP_ST)  ? BP_ST  : cnt_i + 2'd1)
                    : ((cnt_i == BP_SNT) ? BP_SNT : cnt_i - 2'd1);
  end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: bimodal fetch predictor with decode-stage resolve, redirect and stats.
module branch_predict_unit
  import mips_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int STAT_BITS  = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [31:0]          PCF,
  input  logic [31:0]          PCPlus4F,
  input  logic [31:0]          InstructionF,
  output logic                 predictF,
  output logic [31:0]          PCPredF,
  input  logic                 Fetch_Enable,
  input  logic                 BranchD,
  input  logic                 TakenD,
  input  logic                 predictD,
  input  logic [31:0]          PCD,
  input  logic [31:0]          PCPlus4D,
  input  logic [31:0]          PCBranchD,
  output logic                 Flush,
  output logic                 RedirectValidD,
  output logic [31:0]          RedirectPCD,
  output logic [STAT_BITS-1:0] BranchCount,
  output logic [STAT_BITS-1:0] MispredictCount
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  logic [1:0]            table_q [ENTRIES];
  logic [STAT_BITS-1:0]  branch_cnt_q, mispred_cnt_q;
  logic [INDEX_BITS-1:0] idx_f, idx_d;
  logic [1:0]            upd_cnt;
  logic [15:0]           imm;
  logic [31:0]           target_f;
  logic                  is_branch_f, resolve_d, mispred_d;
  logic                  unused_bits;
  assign idx_f = PCF[INDEX_BITS+1:2];
  assign idx_d = PCD[INDEX_BITS+1:2];
  assign imm   = InstructionF[15:0];
  assign unused_bits = ^{PCF[31:INDEX_BITS+2], PCF[1:0], PCD[31:INDEX_BITS+2], PCD[1:0],
                         InstructionF[25:16]};
  always_comb begin
    is_branch_f    = (InstructionF[31:26] == OP_BEQ) || (InstructionF[31:26] == OP_BNE);
    target_f       = PCPlus4F + {{14{imm[15]}}, imm, 2'b00};
    predictF       = is_branch_f & table_q[idx_f][1];
    PCPredF        = predictF ? target_f : PCPlus4F;
    resolve_d      = BranchD & Fetch_Enable & ~Reset;
    mispred_d      = resolve_d & (predictD != TakenD);
    Flush          = mispred_d;
    RedirectValidD = mispred_d;
    RedirectPCD    = TakenD ? PCBranchD : PCPlus4D;
  end
  sat_counter2 u_sat (
    .cnt_i   (table_q[idx_d]),
    .taken_i (TakenD),
    .cnt_o   (upd_cnt)
  );
  // fetch reads table_q directly, so a same-cycle update is only seen next cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= BP_RESET;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (resolve_d) begin
      table_q[idx_d] <= upd_cnt;
      branch_cnt_q   <= branch_cnt_q + STAT_BITS'(~&branch_cnt_q);
      if (mispred_d) mispred_cnt_q <= mispred_cnt_q + STAT_BITS'(~&mispred_cnt_q);
    end
  end
  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed stimulus with a queued scoreboard drained by a negedge monitor.
module tb_branch_predict_unit;
  logic        Clk = 0, Reset;
  logic [31:0] PCF, PCPlus4F, InstructionF, PCPredF;
  logic        predictF, Fetch_Enable, BranchD, TakenD, predictD;
  logic [31:0] PCD, PCPlus4D, PCBranchD, RedirectPCD;
  logic        Flush, RedirectValidD;
  logic [31:0] BranchCount, MispredictCount;
  typedef enum logic [2:0] {S_PRED, S_PCPRED, S_FLUSH, S_RVALID, S_RPC, S_BCNT, S_MCNT} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;
  exp_t q[$];
  int n_vec = 0, n_fail = 0;
  branch_predict_unit dut (
    .Clk(Clk), .Reset(Reset), .PCF(PCF), .PCPlus4F(PCPlus4F), .InstructionF(InstructionF),
    .predictF(predictF), .PCPredF(PCPredF), .Fetch_Enable(Fetch_Enable), .BranchD(BranchD),
    .TakenD(TakenD), .predictD(predictD), .PCD(PCD), .PCPlus4D(PCPlus4D), .PCBranchD(PCBranchD),
    .Flush(Flush), .RedirectValidD(RedirectValidD), .RedirectPCD(RedirectPCD),
    .BranchCount(BranchCount), .MispredictCount(MispredictCount)
  );
  always #5 Clk = ~Clk;
  function automatic logic [31:0] pick(sel_e s);
    case (s)
      S_PRED:   return {31'd0, predictF};
      S_PCPRED: return PCPredF;
      S_FLUSH:  return {31'd0, Flush};
      S_RVALID: return {31'd0, RedirectValidD};
      S_RPC:    return RedirectPCD;
      S_BCNT:   return BranchCount;
      default:  return MispredictCount;
    endcase
  endfunction
  always @(negedge Clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] got;
      e = q.pop_front();
      got = pick(e.sel);
      n_vec++;
      if (got !== e.val) begin
        n_fail++;
        $display("FAIL %s @%0t: got %h want %h", e.name, $time, got, e.val);
      end
    end
  end
  function automatic logic [31:0] beq(logic [15:0] i);
    return {6'b000100, 10'd0, i};
  endfunction
  function automatic logic [31:0] bne(logic [15:0] i);
    return {6'b000101, 10'd0, i};
  endfunction
  task automatic push(string n, sel_e s, logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = s; e.val = v;
    q.push_back(e);
  endtask
  task automatic chk_fetch(logic p, logic [31:0] pc);
    push("predictF", S_PRED, {31'd0, p});
    push("PCPredF", S_PCPRED, pc);
  endtask
  task automatic chk_dec(logic f, logic [31:0] rpc);
    push("Flush", S_FLUSH, {31'd0, f});
    push("RedirectValidD", S_RVALID, {31'd0, f});
    if (f) push("RedirectPCD", S_RPC, rpc);
  endtask
  task automatic chk_cnt(logic [31:0] b, logic [31:0] m);
    push("BranchCount", S_BCNT, b);
    push("MispredictCount", S_MCNT, m);
  endtask
  task automatic fetch(logic [31:0] pc, logic [31:0] ins);
    PCF = pc; PCPlus4F = pc + 32'd4; InstructionF = ins;
  endtask
  task automatic dec(logic bd, logic tk, logic pd, logic [31:0] pcd, logic [31:0] pcb, logic fe);
    BranchD = bd; TakenD = tk; predictD = pd; PCD = pcd; PCPlus4D = pcd + 32'd4;
    PCBranchD = pcb; Fetch_Enable = fe;
  endtask
  task automatic idle();
    dec(0, 0, 0, 32'h0, 32'h0, 1);
  endtask
  task automatic tick();
    @(posedge Clk); #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    Reset = 1; fetch(32'h0, 32'h0); idle();
    tick();
    // held in reset with a would-be mispredict presented
    fetch(32'h40, beq(16'h0010)); dec(1, 1, 0, 32'h40, 32'h100, 1);
    chk_fetch(0, 32'h44); chk_dec(0, 32'h0); tick();
    Reset = 0; idle();
    chk_fetch(0, 32'h44); chk_cnt(0, 0); tick();
    dec(1, 1, 0, 32'h40, 32'h100, 1);
    chk_dec(1, 32'h100); chk_fetch(0, 32'h44); chk_cnt(0, 0); tick();
    idle();
    chk_fetch(1, 32'h84); chk_dec(0, 32'h0); chk_cnt(1, 1); tick();
    repeat (3) begin
      dec(1, 1, 1, 32'h40, 32'h100, 1); chk_dec(0, 32'h0); tick();
    end
    idle(); chk_cnt(4, 1); chk_fetch(1, 32'h84); tick();
    // strong taken -> weak taken, still predicts taken
    dec(1, 0, 1, 32'h40, 32'h100, 1); chk_dec(1, 32'h44); tick();
    idle(); chk_fetch(1, 32'h84); chk_cnt(5, 2); tick();
    dec(1, 0, 1, 32'h40, 32'h100, 1); chk_dec(1, 32'h44); chk_fetch(1, 32'h84); tick();
    idle(); chk_fetch(0, 32'h44); chk_cnt(6, 3); tick();
    repeat (3) begin
      dec(1, 1, 0, 32'h40, 32'h100, 0);
      chk_dec(0, 32'h0); chk_fetch(0, 32'h44); chk_cnt(6, 3); tick();
    end
    dec(1, 1, 0, 32'h40, 32'h100, 1); chk_dec(1, 32'h100); tick();
    idle(); chk_fetch(1, 32'h84); chk_cnt(7, 4); tick();
    fetch(32'h80, beq(16'h0010)); chk_fetch(0, 32'h84); tick();
    fetch(32'h140, beq(16'h0010)); chk_fetch(1, 32'h184); tick();
    fetch(32'h40, bne(16'hFFFF)); chk_fetch(1, 32'h40); tick();
    fetch(32'h40, {6'b000110, 10'd0, 16'h0010}); chk_fetch(0, 32'h44); tick();
    fetch(32'h0, beq(16'h8000)); dec(1, 1, 1, 32'h0, 32'h100, 1);
    chk_fetch(0, 32'h4); chk_dec(0, 32'h0); tick();
    idle(); chk_fetch(1, 32'hFFFE0004); chk_cnt(8, 4); tick();
    fetch(32'h0, 32'h00000020); chk_fetch(0, 32'h4); tick();
    // reset mid-operation drops the pending resolve
    Reset = 1; fetch(32'h40, beq(16'h0010)); dec(1, 1, 0, 32'h40, 32'h100, 1);
    chk_dec(0, 32'h0); tick();
    Reset = 0; idle(); chk_fetch(0, 32'h44); chk_cnt(0, 0); tick();
    fetch(32'h0, beq(16'h8000)); chk_fetch(0, 32'h4); tick();
    @(negedge Clk); #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
